// File: rtl/bclk_training_ctrl.sv
// bclk_training_ctrl
// Eye-training controller for the DDR3 BCLK training IOD lane. Sweeps the
// input delay line from tap 0 upwards, grades each tap with the eye-monitor
// flags, keeps the widest clean window (earliest wins on a tie) and then
// walks the delay line back down to the centre of that window.
//
// Build option: define BCLK_TRAIN_DATA_CHECK_EN to also require RX_DATA to
// read 8'h55 or 8'hAA on every sample cycle; any other value marks the tap bad.
// Without the macro RX_DATA is ignored.
//
// state  | meaning
// IDLE   | waiting for TRAIN_START
// LOAD   | reload the default delay (tap 0)
// CLEAR  | clear the eye-monitor flags for the current tap
// SETTLE | let the lane settle after the flag clear
// SAMPLE | accumulate eye / out-of-range flags for the current tap
// EVAL   | grade the tap, update run and best window, decide sweep end
// STEP   | increment the delay line by one tap
// CENTER | decrement the delay line by one tap towards the centre
// CGAP   | idle gap between centring moves
// DONE   | training succeeded, result presented
// FAIL   | no usable window, delay line reloaded to tap 0

module bclk_training_ctrl #(
    parameter int TAP_W         = 8,
    parameter int MAX_TAPS      = 127,
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLE_CYCLES = 8,
    parameter int MIN_WINDOW    = 2
) (
    input  logic             FAB_CLK,
    input  logic             ARST,
    input  logic             TRAIN_START,
    output logic             TRAIN_BUSY,
    output logic             TRAIN_DONE,
    output logic             TRAIN_FAIL,
    output logic [TAP_W-1:0] TAP_OUT,
    output logic [TAP_W-1:0] WINDOW_OUT,
    input  logic             EYE_MONITOR_EARLY,
    input  logic             EYE_MONITOR_LATE,
    input  logic             DELAY_LINE_OUT_OF_RANGE,
    input  logic [7:0]       RX_DATA,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_LOAD,
    output logic             EYE_MONITOR_CLEAR_FLAGS
);

    // Phase timers are down-counters loaded with (cycles - 1), so the widest
    // one only has to hold the larger of the two loads.
    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(MAX_TAPS);
    localparam logic [TAP_W-1:0] MIN_LEN     = TAP_W'(MIN_WINDOW);
    localparam logic [TAP_W-1:0] ONE         = TAP_W'(1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_STEP,
        ST_CENTER,
        ST_CGAP,
        ST_DONE,
        ST_FAIL
    } state_t;

    state_t           state,      state_nxt;
    logic [CNT_W-1:0] cnt,        cnt_nxt;
    logic [TAP_W-1:0] cur_tap,    cur_tap_nxt;
    logic [TAP_W-1:0] run_start,  run_start_nxt;
    logic [TAP_W-1:0] run_len,    run_len_nxt;
    logic [TAP_W-1:0] best_start, best_start_nxt;
    logic [TAP_W-1:0] best_len,   best_len_nxt;
    logic [TAP_W-1:0] centre,     centre_nxt;
    logic [TAP_W-1:0] remaining,  remaining_nxt;
    logic             bad_acc,    bad_acc_nxt;
    logic             oor_acc,    oor_acc_nxt;

    logic             start_accept;
    logic             tap_clean;
    logic             sweep_end;
    logic             close_run;
    logic [TAP_W-1:0] ext_len;
    logic [TAP_W-1:0] ext_start;
    logic             data_bad;

    logic             done_q;
    logic             fail_q;
    logic [TAP_W-1:0] tap_q;
    logic [TAP_W-1:0] win_q;

`ifdef BCLK_TRAIN_DATA_CHECK_EN
    // Training pattern is alternating 0101/1010; anything else is a bit error.
    assign data_bad = (RX_DATA != 8'h55) && (RX_DATA != 8'hAA);
`else
    logic unused_rx_data;
    assign unused_rx_data = ^RX_DATA;
    assign data_bad       = 1'b0;
`endif

    // State register and sweep datapath.
    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            cur_tap    <= '0;
            run_start  <= '0;
            run_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
            centre     <= '0;
            remaining  <= '0;
            bad_acc    <= 1'b0;
            oor_acc    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            cur_tap    <= cur_tap_nxt;
            run_start  <= run_start_nxt;
            run_len    <= run_len_nxt;
            best_start <= best_start_nxt;
            best_len   <= best_len_nxt;
            centre     <= centre_nxt;
            remaining  <= remaining_nxt;
            bad_acc    <= bad_acc_nxt;
            oor_acc    <= oor_acc_nxt;
        end
    end

    // Next-state, tap grading and window bookkeeping.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        cur_tap_nxt    = cur_tap;
        run_start_nxt  = run_start;
        run_len_nxt    = run_len;
        best_start_nxt = best_start;
        best_len_nxt   = best_len;
        centre_nxt     = centre;
        remaining_nxt  = remaining;
        bad_acc_nxt    = bad_acc;
        oor_acc_nxt    = oor_acc;
        start_accept   = 1'b0;
        tap_clean      = 1'b0;
        sweep_end      = 1'b0;
        close_run      = 1'b0;
        ext_len        = run_len;
        ext_start      = run_start;

        case (state)
            // A start is honoured whenever the controller is not busy,
            // including the single DONE/FAIL presentation cycle.
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (TRAIN_START) begin
                    start_accept   = 1'b1;
                    cur_tap_nxt    = '0;
                    run_start_nxt  = '0;
                    run_len_nxt    = '0;
                    best_start_nxt = '0;
                    best_len_nxt   = '0;
                    centre_nxt     = '0;
                    remaining_nxt  = '0;
                    state_nxt      = ST_LOAD;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_LOAD: begin
                state_nxt = ST_CLEAR;
            end

            ST_CLEAR: begin
                bad_acc_nxt = 1'b0;
                oor_acc_nxt = 1'b0;
                cnt_nxt     = SETTLE_LOAD;
                state_nxt   = ST_SETTLE;
            end

            ST_SETTLE: begin
                if (cnt == '0) begin
                    cnt_nxt   = SAMPLE_LOAD;
                    state_nxt = ST_SAMPLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            ST_SAMPLE: begin
                bad_acc_nxt = bad_acc | EYE_MONITOR_EARLY | EYE_MONITOR_LATE | data_bad;
                oor_acc_nxt = oor_acc | DELAY_LINE_OUT_OF_RANGE;
                if (cnt == '0) begin
                    state_nxt = ST_EVAL;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end

            ST_EVAL: begin
                // An out-of-range tap is not part of any window, even if clean.
                tap_clean = !oor_acc && !bad_acc;
                ext_len   = tap_clean ? (run_len + ONE) : run_len;
                ext_start = (tap_clean && (run_len == '0)) ? cur_tap : run_start;
                sweep_end = oor_acc || (cur_tap == LAST_TAP);
                close_run = !tap_clean || sweep_end;

                if (close_run) begin
                    run_len_nxt = '0;
                    // Strictly greater keeps the earliest of equal windows.
                    if (ext_len > best_len) begin
                        best_len_nxt   = ext_len;
                        best_start_nxt = ext_start;
                    end
                end else begin
                    run_len_nxt   = ext_len;
                    run_start_nxt = ext_start;
                end

                if (!sweep_end) begin
                    state_nxt = ST_STEP;
                end else if (best_len_nxt < MIN_LEN) begin
                    state_nxt = ST_FAIL;
                end else begin
                    centre_nxt    = best_start_nxt + ((best_len_nxt - ONE) >> 1);
                    remaining_nxt = cur_tap - centre_nxt;
                    state_nxt     = (remaining_nxt == '0) ? ST_DONE : ST_CENTER;
                end
            end

            ST_STEP: begin
                cur_tap_nxt = cur_tap + ONE;
                state_nxt   = ST_CLEAR;
            end

            ST_CENTER: begin
                remaining_nxt = remaining - ONE;
                state_nxt     = ST_CGAP;
            end

            ST_CGAP: begin
                state_nxt = (remaining == '0) ? ST_DONE : ST_CENTER;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Result registers: cleared on an accepted start, captured on entry to DONE/FAIL.
    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
            tap_q  <= '0;
            win_q  <= '0;
        end else if (start_accept) begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
            tap_q  <= '0;
            win_q  <= '0;
        end else if (state_nxt == ST_DONE) begin
            done_q <= 1'b1;
            tap_q  <= centre_nxt;
            win_q  <= best_len_nxt;
        end else if (state_nxt == ST_FAIL) begin
            fail_q <= 1'b1;
            tap_q  <= '0;
            win_q  <= best_len_nxt;
        end
    end

    // IOD control strobes decode straight from the state register, so the
    // pulses are one cycle wide and mutually exclusive by construction.
    assign DELAY_LINE_MOVE         = (state == ST_STEP) || (state == ST_CENTER);
    assign DELAY_LINE_DIRECTION    = (state == ST_STEP);
    assign DELAY_LINE_LOAD         = (state == ST_LOAD) || (state == ST_FAIL);
    assign EYE_MONITOR_CLEAR_FLAGS = (state == ST_CLEAR);

    assign TRAIN_BUSY = (state != ST_IDLE) && (state != ST_DONE) && (state != ST_FAIL);
    assign TRAIN_DONE = done_q;
    assign TRAIN_FAIL = fail_q;
    assign TAP_OUT    = tap_q;
    assign WINDOW_OUT = win_q;

endmodule
